// File: rtl/ivs_sched_pkg.sv
// Shared definitions for the IVS slot scheduler.
//   NUM_SLOTS  : number of doorbell slots (fixed at 32 in this revision)
//   SLOT_ID_W  : width of a slot id
//   sched_state_e : scheduler FSM state encoding (also exported on dbg_state)
package ivs_sched_pkg;

  localparam int NUM_SLOTS = 32;
  localparam int SLOT_ID_W = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_CMD = 3'd2,
    S_START    = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ivs_rr_pick.sv
// Combinational round-robin picker over the 32-bit pending set.
// The search starts at last+1 and ascends, wrapping past 31 to 0.
// It is built as rotate -> lowest-set-bit priority encode -> un-rotate.
//   req  : pending request vector
//   last : slot id granted most recently
//   any  : at least one request is set
//   id   : winning slot id (meaningful only when any=1)
module ivs_rr_pick
  import ivs_sched_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [SLOT_ID_W-1:0] last,
  output logic                 any,
  output logic [SLOT_ID_W-1:0] id
);

  logic [SLOT_ID_W-1:0] w_start;
  logic [NUM_SLOTS-1:0] w_rot;
  logic [SLOT_ID_W-1:0] w_pos;
  logic                 w_found;

  // 5-bit arithmetic wraps naturally, so 31+1 starts the search at 0.
  assign w_start = last + SLOT_ID_W'(1);

  // Rotate so that slot w_start lands in bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_rot[i] = req[SLOT_ID_W'(i) + w_start];
    end
  end

  // Lowest set bit of the rotated vector is the winner.
  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_pos   = SLOT_ID_W'(i);
      end
    end
  end

  assign any = |req;
  assign id  = w_pos + w_start;

endmodule

// File: rtl/ivs_slot_sched.sv
// IVS slot scheduler: collects per-slot doorbells into a pending set, picks
// the next slot round-robin, then sequences command fetch, frame start and
// completion reporting, guarded by a watchdog.
//   clk, rst_n      : clock, asynchronous active-low reset
//   sched_en        : allows new grants; an in-flight slot always completes
//   slot_doorbell   : one-cycle per-slot pending pulses
//   timeout_cfg     : watchdog limit in cycles, 0 disables it
//   cmd_fetch_en    : one-cycle fetch request, slot in cmd_slot_sel
//   cmd_resp        : command loaded (honoured only in WAIT_CMD)
//   frm_start       : one-cycle frame-engine kick
//   frm_done        : frame finished (honoured only in RUN)
//   slot_pending    : current pending set
//   sched_busy      : high in every state except IDLE
//   slot_done_*     : completion strobe, slot id and timeout flag
//   dbg_state       : current FSM state
//
// Handshake note: every strobe in or out is a single-cycle pulse with no
// back-pressure. Inputs arriving outside the state that waits for them are
// dropped; all outputs are registered.
module ivs_slot_sched
  import ivs_sched_pkg::*;
#(
  parameter int TMO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en,
  input  logic [NUM_SLOTS-1:0] slot_doorbell,
  input  logic [TMO_W-1:0]     timeout_cfg,
  output logic                 cmd_fetch_en,
  output logic [SLOT_ID_W-1:0] cmd_slot_sel,
  input  logic                 cmd_resp,
  output logic                 frm_start,
  input  logic                 frm_done,
  output logic [NUM_SLOTS-1:0] slot_pending,
  output logic                 sched_busy,
  output logic                 slot_done_vld,
  output logic [SLOT_ID_W-1:0] slot_done_id,
  output logic                 slot_done_err,
  output logic [2:0]           dbg_state
);

  sched_state_e         r_state;
  logic [NUM_SLOTS-1:0] r_pending;
  logic [SLOT_ID_W-1:0] r_last;
  logic [SLOT_ID_W-1:0] r_sel;
  logic [TMO_W-1:0]     r_wdog;
  logic                 r_fetch;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_done_vld;
  logic [SLOT_ID_W-1:0] r_done_id;
  logic                 r_done_err;

  logic                 w_any;
  logic [SLOT_ID_W-1:0] w_pick;
  logic                 w_grant;
  logic [NUM_SLOTS-1:0] w_grant_clear;
  logic                 w_expire;
  logic [TMO_W-1:0]     w_wdog_inc;

  ivs_rr_pick u_pick (
    .req  (r_pending),
    .last (r_last),
    .any  (w_any),
    .id   (w_pick)
  );

  assign w_grant       = (r_state == S_IDLE) && sched_en && w_any;
  assign w_grant_clear = w_grant ? (NUM_SLOTS'(1) << w_pick) : '0;

  assign w_expire   = (timeout_cfg != '0) && (r_wdog == timeout_cfg - TMO_W'(1));
  // Saturate rather than wrap so a disabled watchdog can never alias.
  assign w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + TMO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_last     <= SLOT_ID_W'(NUM_SLOTS - 1);
      r_sel      <= '0;
      r_wdog     <= '0;
      r_fetch    <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done_vld <= 1'b0;
      r_done_id  <= '0;
      r_done_err <= 1'b0;
    end else begin
      // OR-ing the doorbell last lets it win over a same-cycle clear.
      r_pending  <= (r_pending & ~w_grant_clear) | slot_doorbell;
      r_fetch    <= 1'b0;
      r_start    <= 1'b0;
      r_done_vld <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel   <= w_pick;
            r_fetch <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_wdog  <= '0;
          r_state <= S_WAIT_CMD;
        end

        S_WAIT_CMD: begin
          if (cmd_resp) begin
            r_state <= S_START;
          end else if (w_expire) begin
            r_done_vld <= 1'b1;
            r_done_id  <= r_sel;
            r_done_err <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_wdog <= w_wdog_inc;
          end
        end

        // The kick is registered from START, so it is seen in the first
        // RUN cycle: two cycles after cmd_resp.
        S_START: begin
          r_start <= 1'b1;
          r_wdog  <= '0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (frm_done) begin
            r_done_vld <= 1'b1;
            r_done_id  <= r_sel;
            r_done_err <= 1'b0;
            r_state    <= S_DONE;
          end else if (w_expire) begin
            r_done_vld <= 1'b1;
            r_done_id  <= r_sel;
            r_done_err <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_wdog <= w_wdog_inc;
          end
        end

        S_DONE: begin
          r_last  <= r_sel;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_fetch_en  = r_fetch;
  assign cmd_slot_sel  = r_sel;
  assign frm_start     = r_start;
  assign slot_pending  = r_pending;
  assign sched_busy    = r_busy;
  assign slot_done_vld = r_done_vld;
  assign slot_done_id  = r_done_id;
  assign slot_done_err = r_done_err;
  assign dbg_state     = r_state;

endmodule
